// File: rtl/load_store_unit_pkg.sv
// Shared RV32 data-side constants: funct3 access widths, load/store opcodes,
// LSU FSM state encoding and the default bus timeout.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS_REQ,
        S_BUS_RSP,
        S_DONE
    } lsu_state_e;

    // Stores only know SB/SH/SW; loads additionally allow LBU/LHU.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 >= 3'b011;
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed valid/ready data bus between the LSU (master) and memory (slave).
interface lsu_bus_if;
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output valid, we, addr, wstrb, wdata, input ready, rvalid, rdata);
    modport slave  (input valid, we, addr, wstrb, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane logic: store replication/strobes, load extraction with
// sign/zero extension, and request legality/alignment checks.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic        o_illegal,
    output logic        o_misaligned,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign o_illegal    = is_illegal(i_we, i_funct3);
    assign o_misaligned = ((i_funct3[1:0] == 2'b01) && i_lane[0]) ||
                          ((i_funct3[1:0] == 2'b10) && (i_lane != 2'b00));

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_wstrb = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_lane)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_rdata = i_rdata;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit: sequences one core request over the valid/ready bus,
// stalls the core meanwhile and aborts on a bus timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT  // must be >= 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    lsu_bus_if.master   io_bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_done, r_err, r_bus_valid, r_bus_we;
    logic [31:0]   r_rdata, r_bus_addr, r_bus_wdata;
    logic [3:0]    r_bus_wstrb;

    logic          w_illegal, w_misaligned;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata, w_load;

    lsu_align u_align (
        .i_we         (i_req_we),
        .i_funct3     (i_req_funct3),
        .i_lane       (i_req_addr[1:0]),
        .i_wdata      (i_req_wdata),
        .i_rdata      (io_bus.rdata),
        .o_illegal    (w_illegal),
        .o_misaligned (w_misaligned),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_rdata      (w_load)
    );

    // Core request fields are held until done, so extraction can use them live.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wstrb <= '0;
            r_bus_wdata <= '0;
        end else if (i_en) begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        if (w_illegal || w_misaligned) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state     <= S_BUS_REQ;
                            r_cnt       <= TMO_LOAD;
                            r_bus_valid <= 1'b1;
                            r_bus_we    <= i_req_we;
                            r_bus_addr  <= {i_req_addr[31:2], 2'b00};
                            r_bus_wstrb <= i_req_we ? w_wstrb : 4'b0000;
                            r_bus_wdata <= i_req_we ? w_wdata : 32'd0;
                        end
                    end
                end
                S_BUS_REQ: begin
                    if (io_bus.ready) begin
                        r_bus_valid <= 1'b0;
                        if (r_bus_we) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                            r_rdata <= '0;
                        end else begin
                            r_state <= S_BUS_RSP;
                            r_cnt   <= TMO_LOAD;
                        end
                    end else if (r_cnt == '0) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                        r_rdata     <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_BUS_RSP: begin
                    if (io_bus.rvalid) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= w_load;
                    end else if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall = i_req_valid && (r_state != S_DONE);
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;

    assign io_bus.valid = r_bus_valid;
    assign io_bus.we    = r_bus_we;
    assign io_bus.addr  = r_bus_addr;
    assign io_bus.wstrb = r_bus_wstrb;
    assign io_bus.wdata = r_bus_wdata;

endmodule
